// File: rtl/miriscv_gpr_wb_ctrl_if.sv
// Bundle between execute/LSU/decode and the GPR writeback controller.
// master = producers/decode side, slave = miriscv_gpr_wb_ctrl.
interface miriscv_gpr_wb_ctrl_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned GPR_ADDR_WIDTH = 5
);
  logic                      alu_valid_i;
  logic                      alu_ready_o;
  logic [GPR_ADDR_WIDTH-1:0] alu_rd_i;
  logic [XLEN-1:0]           alu_data_i;
  logic                      lsu_valid_i;
  logic [GPR_ADDR_WIDTH-1:0] lsu_rd_i;
  logic [XLEN-1:0]           lsu_data_i;
  logic                      issue_load_i;
  logic [GPR_ADDR_WIDTH-1:0] issue_rd_i;
  logic [GPR_ADDR_WIDTH-1:0] rs1_addr_i;
  logic [GPR_ADDR_WIDTH-1:0] rs2_addr_i;
  logic                      rs1_busy_o;
  logic                      rs2_busy_o;
  logic                      rs1_fwd_o;
  logic                      rs2_fwd_o;
  logic [XLEN-1:0]           fwd_data_o;
  logic                      wr_en_o;
  logic [GPR_ADDR_WIDTH-1:0] wr_addr_o;
  logic [XLEN-1:0]           wr_data_o;
  logic                      err_o;

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output issue_load_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    input  alu_ready_o, rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o, fwd_data_o,
    input  wr_en_o, wr_addr_o, wr_data_o, err_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  issue_load_i, issue_rd_i, rs1_addr_i, rs2_addr_i,
    output alu_ready_o, rs1_busy_o, rs2_busy_o, rs1_fwd_o, rs2_fwd_o, fwd_data_o,
    output wr_en_o, wr_addr_o, wr_data_o, err_o
  );
endinterface

// File: rtl/miriscv_gpr_wb_ctrl.sv
// GPR writeback controller: merges ALU results and load responses into one registered write
// per cycle, tracks outstanding loads for RAW stalls. Define MIRISCV_WB_BYPASS_EN to forward.
module miriscv_gpr_wb_ctrl #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned GPR_ADDR_WIDTH = 5,
  parameter int unsigned ALU_FIFO_DEPTH = 2
) (
  input logic                  clk_i,
  input logic                  arstn_i,
  miriscv_gpr_wb_ctrl_if.slave bus
);
  localparam int unsigned PTR_W = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
  localparam int unsigned NREGS = 2 ** GPR_ADDR_WIDTH;

  typedef logic [GPR_ADDR_WIDTH-1:0] addr_t;
  typedef logic [XLEN-1:0]           data_t;

  addr_t                     fifo_rd_q   [ALU_FIFO_DEPTH];
  data_t                     fifo_data_q [ALU_FIFO_DEPTH];
  logic [ALU_FIFO_DEPTH-1:0] fifo_vld_q;
  logic [PTR_W-1:0]          fifo_wr_ptr_q;
  logic [PTR_W-1:0]          fifo_rd_ptr_q;

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             wr_en_q;
  addr_t            wr_addr_q;
  data_t            wr_data_q;
  logic             err_q;

  logic  fifo_full;
  logic  fifo_empty;
  logic  alu_acc;
  logic  fifo_enq;
  logic  fifo_deq;
  logic  sel_vld;
  addr_t sel_rd;
  data_t sel_data;
  logic  issue_err;
  logic  lsu_err;

  logic [ALU_FIFO_DEPTH-1:0] fifo_hit1;
  logic [ALU_FIFO_DEPTH-1:0] fifo_hit2;
  logic                      rs1_pend;
  logic                      rs2_pend;
  logic                      rs1_out_hit;
  logic                      rs2_out_hit;

  // Ring is full when the write slot is still occupied, empty when the head slot is free.
  assign fifo_full  = fifo_vld_q[fifo_wr_ptr_q];
  assign fifo_empty = !fifo_vld_q[fifo_rd_ptr_q];
  assign alu_acc    = bus.alu_valid_i && !fifo_full;

  assign bus.alu_ready_o = !fifo_full;

  // Source select: LSU beats the FIFO head, which beats a direct ALU pass-through.
  always_comb begin
    sel_vld  = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    fifo_enq = 1'b0;
    fifo_deq = 1'b0;
    if (bus.lsu_valid_i) begin
      sel_vld  = 1'b1;
      sel_rd   = bus.lsu_rd_i;
      sel_data = bus.lsu_data_i;
      fifo_enq = alu_acc;
    end else if (!fifo_empty) begin
      sel_vld  = 1'b1;
      sel_rd   = fifo_rd_q[fifo_rd_ptr_q];
      sel_data = fifo_data_q[fifo_rd_ptr_q];
      fifo_deq = 1'b1;
      fifo_enq = alu_acc;
    end else if (bus.alu_valid_i) begin
      sel_vld  = 1'b1;
      sel_rd   = bus.alu_rd_i;
      sel_data = bus.alu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      fifo_vld_q    <= '0;
      fifo_wr_ptr_q <= '0;
      fifo_rd_ptr_q <= '0;
    end else begin
      if (fifo_deq) begin
        fifo_vld_q[fifo_rd_ptr_q] <= 1'b0;
        fifo_rd_ptr_q             <= fifo_rd_ptr_q + PTR_W'(1);
      end
      if (fifo_enq) begin
        fifo_vld_q[fifo_wr_ptr_q] <= 1'b1;
        fifo_wr_ptr_q             <= fifo_wr_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (fifo_enq) begin
      fifo_rd_q[fifo_wr_ptr_q]   <= bus.alu_rd_i;
      fifo_data_q[fifo_wr_ptr_q] <= bus.alu_data_i;
    end
  end

  // Load scoreboard: a response clears, an issue sets; set wins on the same register.
  always_comb begin
    busy_d = busy_q;
    if (bus.lsu_valid_i) begin
      busy_d[bus.lsu_rd_i] = 1'b0;
    end
    if (bus.issue_load_i && (bus.issue_rd_i != '0)) begin
      busy_d[bus.issue_rd_i] = 1'b1;
    end
  end

  // Re-issuing to a register whose response lands this same cycle is legal.
  assign issue_err = bus.issue_load_i && (bus.issue_rd_i != '0) && busy_q[bus.issue_rd_i] &&
                     !(bus.lsu_valid_i && (bus.lsu_rd_i == bus.issue_rd_i));
  assign lsu_err   = bus.lsu_valid_i && (bus.lsu_rd_i != '0) && !busy_q[bus.lsu_rd_i];

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= sel_vld && (sel_rd != '0);
      if (sel_vld) begin
        wr_addr_q <= sel_rd;
        wr_data_q <= sel_data;
      end
      busy_q <= busy_d;
      if (issue_err || lsu_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.wr_en_o   = wr_en_q;
  assign bus.wr_addr_o = wr_addr_q;
  assign bus.wr_data_o = wr_data_q;
  assign bus.err_o     = err_q;

  for (genvar g = 0; g < ALU_FIFO_DEPTH; g++) begin : g_fifo_hit
    assign fifo_hit1[g] = fifo_vld_q[g] && (fifo_rd_q[g] == bus.rs1_addr_i);
    assign fifo_hit2[g] = fifo_vld_q[g] && (fifo_rd_q[g] == bus.rs2_addr_i);
  end

  assign rs1_pend = busy_q[bus.rs1_addr_i] || (|fifo_hit1) ||
                    (bus.alu_valid_i && (bus.alu_rd_i == bus.rs1_addr_i));
  assign rs2_pend = busy_q[bus.rs2_addr_i] || (|fifo_hit2) ||
                    (bus.alu_valid_i && (bus.alu_rd_i == bus.rs2_addr_i));

  assign rs1_out_hit = wr_en_q && (wr_addr_q == bus.rs1_addr_i);
  assign rs2_out_hit = wr_en_q && (wr_addr_q == bus.rs2_addr_i);

`ifdef MIRISCV_WB_BYPASS_EN
  // Output-stage hits are served from the forward path instead of stalling.
  assign bus.rs1_busy_o = (bus.rs1_addr_i != '0) && rs1_pend;
  assign bus.rs2_busy_o = (bus.rs2_addr_i != '0) && rs2_pend;
  assign bus.rs1_fwd_o  = (bus.rs1_addr_i != '0) && rs1_out_hit;
  assign bus.rs2_fwd_o  = (bus.rs2_addr_i != '0) && rs2_out_hit;
  assign bus.fwd_data_o = wr_data_q;
`else
  assign bus.rs1_busy_o = (bus.rs1_addr_i != '0) && (rs1_pend || rs1_out_hit);
  assign bus.rs2_busy_o = (bus.rs2_addr_i != '0) && (rs2_pend || rs2_out_hit);
  assign bus.rs1_fwd_o  = 1'b0;
  assign bus.rs2_fwd_o  = 1'b0;
  assign bus.fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_miriscv_gpr_wb_ctrl.sv
// Self-checking bench for miriscv_gpr_wb_ctrl: directed scenarios plus random traffic against a
// queue-based reference model; expected GPR writes are scoreboarded and checked by a monitor.
module tb_miriscv_gpr_wb_ctrl;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  miriscv_gpr_wb_ctrl_if #(.XLEN(32), .GPR_ADDR_WIDTH(5)) bus ();

  miriscv_gpr_wb_ctrl #(.XLEN(32), .GPR_ADDR_WIDTH(5), .ALU_FIFO_DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .arstn_i(arstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference state: pending ALU results, outstanding loads, last write, sticky error.
  wr_t         m_fifo[$];
  wr_t         exp_q[$];
  logic [31:0] m_busy = '0;
  logic        m_err = 1'b0;
  logic        m_out_en = 1'b0;
  wr_t         m_out = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_busy(input logic [4:0] rs, input logic av, input logic [4:0] ar);
    if (rs == 5'd0) return 1'b0;
    if (m_busy[rs]) return 1'b1;
    foreach (m_fifo[k]) if (m_fifo[k].rd == rs) return 1'b1;
    if (av && ar == rs) return 1'b1;
`ifndef MIRISCV_WB_BYPASS_EN
    if (m_out_en && m_out.rd == rs) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic exp_fwd(input logic [4:0] rs);
`ifdef MIRISCV_WB_BYPASS_EN
    return (rs != 5'd0) && m_out_en && (m_out.rd == rs);
`else
    return (rs != 5'd0) && 1'b0;
`endif
  endfunction

  // One cycle of stimulus: drive, check combinational/registered status, advance the model.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ir,
                      input logic [4:0] r1, input logic [4:0] r2, output logic acc);
    logic e_ready;
    logic sel;
    wr_t  w;
    wr_t  a;
    @(negedge clk);
    arstn            = 1'b1;
    bus.alu_valid_i  = av;
    bus.alu_rd_i     = ar;
    bus.alu_data_i   = ad;
    bus.lsu_valid_i  = lv;
    bus.lsu_rd_i     = lr;
    bus.lsu_data_i   = ld;
    bus.issue_load_i = iv;
    bus.issue_rd_i   = ir;
    bus.rs1_addr_i   = r1;
    bus.rs2_addr_i   = r2;
    #1;
    e_ready = (m_fifo.size() < DEPTH);
    acc     = av && e_ready;
    chk("alu_ready", 32'(bus.alu_ready_o), 32'(e_ready));
    chk("rs1_busy", 32'(bus.rs1_busy_o), 32'(exp_busy(r1, av, ar)));
    chk("rs2_busy", 32'(bus.rs2_busy_o), 32'(exp_busy(r2, av, ar)));
    chk("rs1_fwd", 32'(bus.rs1_fwd_o), 32'(exp_fwd(r1)));
    chk("rs2_fwd", 32'(bus.rs2_fwd_o), 32'(exp_fwd(r2)));
`ifdef MIRISCV_WB_BYPASS_EN
    if (exp_fwd(r1) || exp_fwd(r2)) chk("fwd_data", bus.fwd_data_o, m_out.data);
`else
    chk("fwd_data", bus.fwd_data_o, 32'd0);
`endif
    chk("err", 32'(bus.err_o), 32'(m_err));

    a   = '{rd: ar, data: ad};
    w   = '0;
    sel = 1'b1;
    if (lv) begin
      w = '{rd: lr, data: ld};
      if (acc) m_fifo.push_back(a);
    end else if (m_fifo.size() > 0) begin
      w = m_fifo.pop_front();
      if (acc) m_fifo.push_back(a);
    end else if (av) begin
      w = a;
    end else begin
      sel = 1'b0;
    end
    if (iv && ir != 5'd0 && m_busy[ir] && !(lv && lr == ir)) m_err = 1'b1;
    if (lv && lr != 5'd0 && !m_busy[lr]) m_err = 1'b1;
    if (lv) m_busy[lr] = 1'b0;
    if (iv && ir != 5'd0) m_busy[ir] = 1'b1;
    m_out_en = sel && (w.rd != 5'd0);
    if (sel) m_out = w;
    if (m_out_en) exp_q.push_back(w);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    logic acc;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r1, r2, acc);
  endtask

  task automatic issue(input logic [4:0] rd);
    logic acc;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, rd, 5'd0, 5'd0, acc);
  endtask

  task automatic expect_wr(input string tag, input logic en, input logic [4:0] a,
                           input logic [31:0] d);
    @(posedge clk);
    #1;
    chk({tag, "_en"}, 32'(bus.wr_en_o), 32'(en));
    if (en) begin
      chk({tag, "_addr"}, 32'(bus.wr_addr_o), 32'(a));
      chk({tag, "_data"}, bus.wr_data_o, d);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    chk("t6_pre_full", 32'(bus.alu_ready_o), 32'd0);
    arstn            = 1'b0;
    bus.alu_valid_i  = 1'b0;
    bus.lsu_valid_i  = 1'b0;
    bus.issue_load_i = 1'b0;
    bus.rs1_addr_i   = 5'd22;
    bus.rs2_addr_i   = 5'd0;
    #1;
    chk("t6_pre_busy", 32'(bus.rs1_busy_o), 32'd1);
    m_fifo.delete();
    exp_q.delete();
    m_busy   = '0;
    m_err    = 1'b0;
    m_out_en = 1'b0;
    m_out    = '0;
    @(posedge clk);
    #1;
    chk("t6_wr_en", 32'(bus.wr_en_o), 32'd0);
    chk("t6_ready", 32'(bus.alu_ready_o), 32'd1);
    chk("t6_err", 32'(bus.err_o), 32'd0);
    chk("t6_busy", 32'(bus.rs1_busy_o), 32'd0);
  endtask

  // Monitor: every cycle the output either carries the next expected write or is idle.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("mon_wr_en", 32'(bus.wr_en_o), 32'd1);
          chk("mon_wr_addr", 32'(bus.wr_addr_o), 32'(e.rd));
          chk("mon_wr_data", bus.wr_data_o, e.data);
        end else begin
          chk("mon_wr_idle", 32'(bus.wr_en_o), 32'd0);
        end
      end
    end
  end

  initial begin
    logic        acc;
    logic        av;
    logic        lv;
    logic        iv;
    logic [4:0]  ar;
    logic [4:0]  lr;
    logic [4:0]  ir;
    logic [31:0] ad;
    logic        hold_v;
    int unsigned cand[$];

    bus.alu_valid_i  = 1'b0;
    bus.alu_rd_i     = '0;
    bus.alu_data_i   = '0;
    bus.lsu_valid_i  = 1'b0;
    bus.lsu_rd_i     = '0;
    bus.lsu_data_i   = '0;
    bus.issue_load_i = 1'b0;
    bus.issue_rd_i   = '0;
    bus.rs1_addr_i   = 5'd7;
    bus.rs2_addr_i   = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(bus.wr_en_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_ready", 32'(bus.alu_ready_o), 32'd1);
    chk("rst_busy", 32'(bus.rs1_busy_o), 32'd0);
    mon_en = 1'b1;

    // ALU only
    step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, acc);
    expect_wr("t1", 1'b1, 5'd5, 32'hDEAD_BEEF);

    // LSU/ALU collision, then FIFO fill
    issue(5'd3);
    step(1'b1, 5'd4, 32'h22, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 5'd0, 5'd0, acc);
    expect_wr("t2a", 1'b1, 5'd3, 32'h11);
    idle(5'd4, 5'd0);
    expect_wr("t2b", 1'b1, 5'd4, 32'h22);
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    step(1'b1, 5'd13, 32'hA13, 1'b1, 5'd10, 32'hB10, 1'b0, 5'd0, 5'd13, 5'd10, acc);
    step(1'b1, 5'd14, 32'hA14, 1'b1, 5'd11, 32'hB11, 1'b0, 5'd0, 5'd14, 5'd13, acc);
    step(1'b1, 5'd15, 32'hA15, 1'b1, 5'd12, 32'hB12, 1'b0, 5'd0, 5'd15, 5'd14, acc);
    chk("t2_full", 32'(bus.alu_ready_o), 32'd0);
    for (int k = 0; k < 6 && !acc; k++)
      step(1'b1, 5'd15, 32'hA15, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd15, 5'd13, acc);
    chk("t2_drain_acc", 32'(acc), 32'd1);
    repeat (3) idle(5'd15, 5'd14);

    // x0 destination
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, acc);
    chk("t3_busy", 32'(bus.rs1_busy_o), 32'd0);
    expect_wr("t3", 1'b0, 5'd0, 32'd0);

    // Bypass / output-stage stall
    step(1'b1, 5'd6, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, acc);
    idle(5'd0, 5'd6);
`ifdef MIRISCV_WB_BYPASS_EN
    chk("t5_fwd", 32'(bus.rs2_fwd_o), 32'd1);
    chk("t5_fwd_data", bus.fwd_data_o, 32'h1234);
    chk("t5_busy", 32'(bus.rs2_busy_o), 32'd0);
`else
    chk("t5_busy", 32'(bus.rs2_busy_o), 32'd1);
    chk("t5_fwd", 32'(bus.rs2_fwd_o), 32'd0);
`endif

    // Scoreboard and error detection
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, acc);
    idle(5'd7, 5'd0);
    chk("t4_busy7", 32'(bus.rs1_busy_o), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd0, acc);
    repeat (2) idle(5'd7, 5'd0);
    chk("t4_free7", 32'(bus.rs1_busy_o), 32'd0);
    issue(5'd9);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd0, 5'd0, acc);
    repeat (2) idle(5'd9, 5'd0);
    chk("t4_busy9", 32'(bus.rs1_busy_o), 32'd1);
    chk("t4_err0", 32'(bus.err_o), 32'd0);
    issue(5'd7);
    issue(5'd7);
    idle(5'd0, 5'd0);
    chk("t4_err1", 32'(bus.err_o), 32'd1);

    // Reset with two entries in the FIFO
    issue(5'd20);
    issue(5'd21);
    step(1'b1, 5'd22, 32'hC22, 1'b1, 5'd20, 32'hD20, 1'b0, 5'd0, 5'd0, 5'd0, acc);
    step(1'b1, 5'd23, 32'hC23, 1'b1, 5'd21, 32'hD21, 1'b0, 5'd0, 5'd0, 5'd0, acc);
    do_reset();

    // Random traffic: only legal load issue/response, ALU held until accepted
    hold_v = 1'b0;
    ar     = '0;
    ad     = '0;
    for (int c = 0; c < 400; c++) begin
      if (!hold_v) begin
        av = ($urandom_range(0, 2) != 0);
        ar = 5'($urandom_range(0, 7));
        ad = $urandom;
      end else begin
        av = 1'b1;
      end
      cand.delete();
      for (int r = 1; r < 32; r++) if (m_busy[r]) cand.push_back(r);
      lv = 1'b0;
      lr = '0;
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        lv = 1'b1;
        lr = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      iv = ($urandom_range(0, 3) == 0);
      ir = 5'($urandom_range(0, 7));
      if (iv && m_busy[ir] && !(lv && lr == ir)) iv = 1'b0;
      step(av, ar, ad, lv, lr, $urandom, iv, ir,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), acc);
      hold_v = av && !acc;
    end
    repeat (DEPTH + 2) idle(5'd0, 5'd0);
    @(posedge clk);
    #2;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
